// File: rtl/i281_pkg.sv
// i281_pkg: shared definitions for the i281 fetch-side logic.
//   PC_W, INSTR_W   : default PC / code-memory address width and instruction width
//   pc_seq_state_t  : pc_sequencer FSM state encoding
//   sext_offset()   : sign-extends a narrow two's-complement field to 32 bits
package i281_pkg;

   localparam int PC_W    = 6;
   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      ISSUE = 3'd3,
      HALT  = 3'd4
   } pc_seq_state_t;

   // Sign-extend the low 'width' bits of 'raw' to 32 bits (width in 1..31).
   function automatic logic [31:0] sext_offset(input logic [31:0] raw,
                                               input int unsigned width);
      logic [31:0] sign_bit;
      logic [31:0] hi_mask;
      sign_bit = 32'd1 << (width - 1);
      hi_mask  = ~((32'd1 << width) - 32'd1);
      if ((raw & sign_bit) != 32'd0) begin
         return raw | hi_mask;
      end
      return raw & ~hi_mask;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-register handshake between the fetch sequencer
// and decode.
//   ir_out, fetched_pc, ir_valid   : sequencer -> decode
//   ir_ready, branch_taken,
//   branch_offset, halt_req         : decode -> sequencer
// Handshake: a transfer happens on every rising clock edge where
// ir_valid & ir_ready are both 1. While ir_valid is 1 and ir_ready is 0 the
// sequencer holds ir_out/fetched_pc stable. branch_taken, branch_offset and
// halt_req are only looked at on the transfer cycle.
interface pc_sequencer_if #(
   parameter int PC_W    = i281_pkg::PC_W,
   parameter int INSTR_W = i281_pkg::INSTR_W
) ();

   logic [INSTR_W-1:0] ir_out;
   logic [PC_W-1:0]    fetched_pc;
   logic               ir_valid;
   logic               ir_ready;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_offset;
   logic               halt_req;

   modport master (
      output ir_out,
      output fetched_pc,
      output ir_valid,
      input  ir_ready,
      input  branch_taken,
      input  branch_offset,
      input  halt_req
   );

   modport slave (
      input  ir_out,
      input  fetched_pc,
      input  ir_valid,
      output ir_ready,
      output branch_taken,
      output branch_offset,
      output halt_req
   );

endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC adder.
//   pc_reg        : current PC
//   branch_taken  : 1 selects pc_reg + sign-extended branch_offset, 0 selects pc_reg + 1
//   branch_offset : two's-complement offset
//   next_pc       : result, wrapping mod 2^PC_W
module pc_next_calc #(
   parameter int PC_W = i281_pkg::PC_W
) (
   input  logic [PC_W-1:0] pc_reg,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_offset,
   output logic [PC_W-1:0] next_pc
);
   import i281_pkg::*;

   logic [PC_W-1:0] step;

   always_comb begin
      step = PC_W'(1);
      if (branch_taken) begin
         step = PC_W'(sext_offset(32'(branch_offset), PC_W));
      end
   end

   // Truncating add gives the mod 2^PC_W wrap for both directions.
   assign next_pc = pc_reg + step;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: i281 fetch sequencer driving the PC register write port.
//   clock, reset_n    : rising-edge clock, asynchronous active-low reset
//   pc_reg            : current PC register value
//   c3, pc_input      : PC register write enable / write data
//   imem_addr         : code-memory address (= pc_reg)
//   imem_rdata        : code-memory data, valid one cycle after the address
//   halted            : sequencer stopped until reset
//   state_dbg         : current FSM state, for observation
//   dec_if            : instruction-register handshake towards decode
// Sequence per instruction: FETCH (address out), WAIT (capture IR, PC += 1),
// ISSUE (offer IR until decode takes it; optional branch write or halt).
module pc_sequencer #(
   parameter int PC_W    = i281_pkg::PC_W,
   parameter int INSTR_W = i281_pkg::INSTR_W
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [PC_W-1:0]         pc_reg,
   output logic                    c3,
   output logic [PC_W-1:0]         pc_input,
   output logic [PC_W-1:0]         imem_addr,
   input  logic [INSTR_W-1:0]      imem_rdata,
   output logic                    halted,
   output i281_pkg::pc_seq_state_t state_dbg,
   pc_sequencer_if.master          dec_if
);
   import i281_pkg::*;

   pc_seq_state_t      state_q;
   pc_seq_state_t      state_d;
   logic [INSTR_W-1:0] ir_out_q;
   logic [PC_W-1:0]    fetched_pc_q;
   logic               ir_valid;
   logic               take_branch;
   logic [PC_W-1:0]    next_pc;

   assign imem_addr = pc_reg;
   assign state_dbg = state_q;

   // Branch selection only matters on a non-halting handshake; in WAIT the
   // adder must produce the plain increment whatever decode is driving.
   assign take_branch = (state_q == ISSUE) & dec_if.ir_ready &
                        ~dec_if.halt_req & dec_if.branch_taken;

   pc_next_calc #(
      .PC_W(PC_W)
   ) u_pc_next_calc (
      .pc_reg       (pc_reg),
      .branch_taken (take_branch),
      .branch_offset(dec_if.branch_offset),
      .next_pc      (next_pc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      c3       = 1'b0;
      pc_input = '0;
      ir_valid = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            c3       = 1'b1;
            pc_input = next_pc;
            state_d  = ISSUE;
         end
         ISSUE: begin
            ir_valid = 1'b1;
            if (dec_if.ir_ready) begin
               if (dec_if.halt_req) begin
                  state_d = HALT;
               end else begin
                  state_d = FETCH;
                  if (dec_if.branch_taken) begin
                     c3       = 1'b1;
                     pc_input = next_pc;
                  end
               end
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Instruction register: loaded once per fetch, at the WAIT -> ISSUE edge,
   // so it stays stable for the whole ISSUE stall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ir_out_q     <= '0;
         fetched_pc_q <= '0;
      end else if (state_q == WAIT) begin
         ir_out_q     <= imem_rdata;
         fetched_pc_q <= pc_reg;
      end
   end

   assign dec_if.ir_out     = ir_out_q;
   assign dec_if.fetched_pc = fetched_pc_q;
   assign dec_if.ir_valid   = ir_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a transaction-level
// model (fetch address, cycle position within the fetch) and a scoreboard of
// expected instructions.
module tb_pc_sequencer;

   logic        clock;
   logic        reset_n;
   logic [5:0]  pc_reg;
   logic        c3;
   logic [5:0]  pc_input;
   logic [5:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        halted;
   i281_pkg::pc_seq_state_t state_dbg;

   pc_sequencer_if #(.PC_W(6), .INSTR_W(16)) dec_if ();

   pc_sequencer #(
      .PC_W   (6),
      .INSTR_W(16)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .pc_reg    (pc_reg),
      .c3        (c3),
      .pc_input  (pc_input),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .halted    (halted),
      .state_dbg (state_dbg),
      .dec_if    (dec_if)
   );

   // ---------------- clock / reset / system-side models ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [15:0] mem [64];
   initial begin
      for (int n = 0; n < 64; n++) mem[n] = 16'h1000 + 16'(n);
   end

   always @(posedge clock) imem_rdata <= mem[imem_addr];

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) pc_reg <= 6'd0;
      else if (c3) pc_reg <= pc_input;
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int br_target(input int pc, input logic [5:0] off);
      int s;
      s = off[5] ? int'(off) - 64 : int'(off);
      return (((pc + 1 + s) % 64) + 64) % 64;
   endfunction

   // ---------------- behavioural model + compare process ----------------
   // m_cyc: -1 idle after reset, 0 fetch cycle, 1 wait cycle, 2+ issuing.
   int          m_cyc    = -1;
   int          m_pc     = 0;
   logic [15:0] m_ir     = '0;
   int          m_fpc    = 0;
   bit          m_halted = 1'b0;
   int          cyc_n    = 0;
   int          c3_count = 0;
   logic [15:0] exp_q [$];
   logic [15:0] ir_log [$];
   int          hs_cyc_q [$];
   bit          exp_valid;
   bit          exp_c3;
   bit          hs;
   logic [15:0] exp_ir;

   always @(negedge clock) begin
      if (!reset_n) begin
         check("rst_c3", c3, 0);
         check("rst_pc_input", pc_input, 0);
         check("rst_ir_valid", dec_if.ir_valid, 0);
         check("rst_halted", halted, 0);
         check("rst_ir_out", dec_if.ir_out, 0);
         check("rst_fetched_pc", dec_if.fetched_pc, 0);
         m_cyc = -1; m_pc = 0; m_ir = '0; m_fpc = 0; m_halted = 1'b0;
         exp_q.delete();
      end else begin
         cyc_n++;
         if (c3) c3_count++;
         check("imem_addr", imem_addr, pc_reg);
         check("ir_out_hold", dec_if.ir_out, m_ir);
         check("fetched_pc_hold", dec_if.fetched_pc, m_fpc);
         if (m_halted) begin
            check("halt_halted", halted, 1);
            check("halt_ir_valid", dec_if.ir_valid, 0);
            check("halt_c3", c3, 0);
         end else begin
            exp_valid = (m_cyc >= 2);
            hs        = exp_valid && dec_if.ir_ready;
            exp_c3    = (m_cyc == 1) || (hs && !dec_if.halt_req && dec_if.branch_taken);
            check("ir_valid", dec_if.ir_valid, exp_valid);
            check("halted", halted, 0);
            check("c3", c3, exp_c3);
            if (m_cyc == 1) check("pc_input_inc", pc_input, (m_pc + 1) % 64);
            else if (exp_c3) check("pc_input_br", pc_input, br_target(m_pc, dec_if.branch_offset));
            if (m_cyc == 0 || m_cyc == 1) check("pc_reg_fetch", pc_reg, m_pc);
            else if (m_cyc >= 2) check("pc_reg_issue", pc_reg, (m_pc + 1) % 64);
            if (m_cyc == 1) begin
               m_ir  = 16'(32'h1000 + m_pc);
               m_fpc = m_pc;
               exp_q.push_back(m_ir);
               m_cyc = 2;
            end else if (hs) begin
               exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
               check("sb_ir", dec_if.ir_out, exp_ir);
               ir_log.push_back(dec_if.ir_out);
               hs_cyc_q.push_back(cyc_n);
               if (dec_if.halt_req) begin
                  m_halted = 1'b1;
               end else begin
                  m_pc  = dec_if.branch_taken ? br_target(m_pc, dec_if.branch_offset)
                                              : (m_pc + 1) % 64;
                  m_cyc = 0;
               end
            end else if (m_cyc < 2) begin
               m_cyc++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      dec_if.ir_ready      = 1'b0;
      dec_if.branch_taken  = 1'($urandom_range(0, 1));
      dec_if.branch_offset = 6'($urandom_range(0, 63));
      dec_if.halt_req      = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (dec_if.ir_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check({name, "_valid_timeout"}, dec_if.ir_valid, 1);
   endtask

   task automatic handshake(input string name, input bit br, input logic [5:0] off,
                            input bit hlt, input bit exp_w, input logic [5:0] exp_pc);
      dec_if.ir_ready      = 1'b1;
      dec_if.branch_taken  = br;
      dec_if.branch_offset = off;
      dec_if.halt_req      = hlt;
      #1;
      check({name, "_c3"}, c3, exp_w);
      if (exp_w) check({name, "_pc_input"}, pc_input, exp_pc);
      tick();
      idle_inputs();
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_c3"}, c3, 0);
      check({name, "_pc_input"}, pc_input, 0);
      check({name, "_ir_valid"}, dec_if.ir_valid, 0);
      check({name, "_halted"}, halted, 0);
      check({name, "_ir_out"}, dec_if.ir_out, 0);
      check({name, "_fetched_pc"}, dec_if.fetched_pc, 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int waited;
      reset_n              = 1'b0;
      dec_if.ir_ready      = 1'b0;
      dec_if.branch_taken  = 1'b0;
      dec_if.branch_offset = 6'd0;
      dec_if.halt_req      = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_zero_outputs("reset");
      check("reset_imem_addr", imem_addr, 0);

      // Streaming with ready tied high.
      dec_if.ir_ready = 1'b1;
      reset_n = 1'b1;
      waited = 0;
      while (ir_log.size() < 3 && waited < 40) begin
         tick();
         waited++;
      end
      check("stream_count", ir_log.size(), 3);
      dec_if.ir_ready = 1'b0;
      check("stream_ir0", ir_log[0], 16'h1000);
      check("stream_ir1", ir_log[1], 16'h1001);
      check("stream_ir2", ir_log[2], 16'h1002);
      check("stream_period01", hs_cyc_q[1] - hs_cyc_q[0], 3);
      check("stream_period12", hs_cyc_q[2] - hs_cyc_q[1], 3);
      check("stream_c3_pulses", c3_count, 3);

      // Decode stall for 5 cycles.
      wait_valid("stall");
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", dec_if.ir_valid, 1);
         check("stall_ir_out", dec_if.ir_out, 16'h1003);
         check("stall_fetched_pc", dec_if.fetched_pc, 3);
         check("stall_c3", c3, 0);
         check("stall_pc_reg", pc_reg, 4);
         tick();
         idle_inputs();
      end
      handshake("stall_release", 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);

      // Branches: 5 -> 10, then PC 10 with -3 -> 8.
      wait_valid("br_a");
      check("br_a_fetched_pc", dec_if.fetched_pc, 4);
      handshake("br_a", 1'b1, 6'd5, 1'b0, 1'b1, 6'd10);
      wait_valid("br_b");
      check("br_b_fetched_pc", dec_if.fetched_pc, 10);
      check("br_b_ir_out", dec_if.ir_out, 16'h100A);
      handshake("br_b", 1'b1, 6'h3D, 1'b0, 1'b1, 6'd8);
      wait_valid("br_c");
      check("br_c_fetched_pc", dec_if.fetched_pc, 8);
      check("br_c_ir_out", dec_if.ir_out, 16'h1008);

      // Jump to 63 and check the increment wraps to 0 in WAIT.
      handshake("to63", 1'b1, 6'h36, 1'b0, 1'b1, 6'd63);
      tick();
      check("wrap_wait_c3", c3, 1);
      check("wrap_wait_pc_input", pc_input, 0);
      wait_valid("wrap63");
      check("wrap63_fetched_pc", dec_if.fetched_pc, 63);
      check("wrap63_pc_reg", pc_reg, 0);
      handshake("wrap63", 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      wait_valid("pc0");
      check("pc0_fetched_pc", dec_if.fetched_pc, 0);
      handshake("pc0", 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      wait_valid("pc1");
      check("pc1_pc_reg", pc_reg, 2);
      handshake("back_wrap", 1'b1, 6'h3B, 1'b0, 1'b1, 6'd61);
      wait_valid("pc61");
      check("pc61_fetched_pc", dec_if.fetched_pc, 61);
      check("pc61_ir_out", dec_if.ir_out, 16'h103D);

      // Halt beats branch on the same handshake.
      handshake("halt", 1'b1, 6'd5, 1'b1, 1'b0, 6'd0);
      for (int i = 0; i < 20; i++) begin
         check("halt_hold_halted", halted, 1);
         check("halt_hold_ir_valid", dec_if.ir_valid, 0);
         check("halt_hold_c3", c3, 0);
         check("halt_hold_pc_reg", pc_reg, 62);
         tick();
         idle_inputs();
         dec_if.ir_ready = 1'($urandom_range(0, 1));
      end

      // Reset during HALT.
      idle_inputs();
      reset_n = 1'b0;
      #1;
      check_zero_outputs("rst_in_halt");
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
      check("restart1_imem_addr", imem_addr, 0);
      check("restart1_ir_valid", dec_if.ir_valid, 0);
      wait_valid("restart1");
      check("restart1_fetched_pc", dec_if.fetched_pc, 0);
      check("restart1_ir_out", dec_if.ir_out, 16'h1000);

      // Reset during WAIT.
      handshake("pre_wait", 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      tick();
      check("in_wait_c3", c3, 1);
      check("in_wait_pc_input", pc_input, 2);
      reset_n = 1'b0;
      #1;
      check_zero_outputs("rst_in_wait");
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
      check("restart2_imem_addr", imem_addr, 0);
      wait_valid("restart2");
      check("restart2_fetched_pc", dec_if.fetched_pc, 0);
      check("restart2_ir_out", dec_if.ir_out, 16'h1000);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side sequencer for the i281 toy CPU, the block that drives the PC register's write port. It reads the current PC, fetches the instruction from synchronous code memory, and holds it in an instruction register. It hands the instruction to decode with a valid/ready handshake. It writes the PC back through `pc_input`/`c3` for sequential advance and taken branches.

## Interface
Parameters:
- `PC_W`, 6, PC and code-memory address width (64 words)
- `INSTR_W`, 16, instruction width

Ports:
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pc_reg`  in  PC_W  current PC register value
- `c3`  out  1  PC write enable
- `pc_input`  out  PC_W  PC write data
- `imem_addr`  out  PC_W  code-memory read address; combinational, equals `pc_reg`
- `imem_rdata`  in  INSTR_W  code-memory data, valid one cycle after address
- `ir_out`  out  INSTR_W  instruction register
- `fetched_pc`  out  PC_W  address `ir_out` was fetched from
- `ir_valid`  out  1  `ir_out` holds an unconsumed instruction
- `ir_ready`  in  1  decode accepts `ir_out`
- `branch_taken`  in  1  sampled only on the handshake cycle
- `branch_offset`  in  PC_W  two's-complement offset, sampled with `branch_taken`
- `halt_req`  in  1  sampled only on the handshake cycle
- `halted`  out  1  sequencer stopped

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE: entered on reset. Moves to FETCH on the next clock.
- FETCH: `imem_addr` = `pc_reg`. Moves to WAIT unconditionally.
- WAIT:
  - capture `imem_rdata` into `ir_out` and `pc_reg` into `fetched_pc`;
  - assert `c3` with `pc_input` = `pc_reg` + 1, mod 2^PC_W;
  - move to ISSUE.
- ISSUE: `ir_valid` = 1. `ir_out` and `fetched_pc` are held stable while `ir_ready` = 0.
- Handshake is `ir_valid` & `ir_ready`. On the handshake cycle:
  - `halt_req` = 1: go to HALT. No PC write; `halt_req` has priority over `branch_taken`.
  - else `branch_taken` = 1: assert `c3` with `pc_input` = `pc_reg` + sign-extended `branch_offset`, mod 2^PC_W. `pc_reg` already equals `fetched_pc` + 1, giving i281 PC+1+offset semantics. Go to FETCH.
  - else: go to FETCH with no PC write.
- HALT:
  - `halted` = 1 and `ir_valid` = 0;
  - `c3` is never asserted;
  - only `reset_n` exits this state.
- `c3` is 0 in all cases not listed above.
- `c3` is asserted for exactly one cycle per WAIT and at most one cycle per handshake.
- Wrap-around:
  - PC 63 + 1 → 0;
  - PC 2 + offset −5 (0x3B) → 61.
- Reset (`reset_n` low), at any time including mid-fetch or mid-handshake, asynchronously forces:
  - state IDLE;
  - `ir_out` = 0, `fetched_pc` = 0;
  - `ir_valid` = 0, `halted` = 0;
  - `c3` = 0, `pc_input` = 0.
- `imem_addr` under reset follows `pc_reg`, which the system resets to 0 from the same reset source (inverted).

## Timing
- `c3`, `pc_input`, `ir_valid`, `halted`: combinational from state and inputs; no registered delay.
- `ir_out`, `fetched_pc`: registered at the WAIT→ISSUE edge.
- Latency: FETCH to `ir_valid` high = 2 cycles (FETCH, WAIT).
- Throughput: with `ir_ready` tied high, one instruction every 3 cycles (FETCH, WAIT, ISSUE).
- A PC write in WAIT is visible in `pc_reg` in ISSUE.
- A PC write on the handshake cycle is visible in `pc_reg` in the following FETCH, so the next fetch uses the updated PC.
- `branch_taken`, `branch_offset` and `halt_req` are ignored outside the handshake cycle.

## Structure
- Shared package `i281_pkg`:
  - `PC_W`, `INSTR_W` constants;
  - FSM state typedef `pc_seq_state_t`;
  - sign-extension helper for PC offsets.
- One natural combinational sub-module, `pc_next_calc`:
  - inputs `pc_reg`, `branch_taken`, `branch_offset`, and select between increment and branch;
  - outputs the next PC.
- Everything else lives in `pc_sequencer`.

## Test plan
- Reset, release, `ir_ready` = 1, code memory word n = 0x1000+n: `ir_out` shows 0x1000, 0x1001, 0x1002 on consecutive 3-cycle periods; `c3` pulses once per instruction, in WAIT.
- `ir_ready` held 0 for 5 cycles in ISSUE: `ir_valid` stays 1; `ir_out`/`fetched_pc` stable; `c3` = 0; `pc_reg` unchanged after its WAIT increment.
- Instruction at PC 10, handshake with `branch_taken` = 1, `branch_offset` = 0x3D (−3): `pc_input` = 8 with `c3` on the handshake cycle; next `fetched_pc` = 8.
- PC 63 fetch: `pc_input` = 0 in WAIT. PC 2 branch with offset 0x3B: target 61 (wrap-around).
- `halt_req` = 1 and `branch_taken` = 1 on the same handshake: `halted` = 1, no `c3`, `ir_valid` = 0 for 20 cycles.
- `reset_n` low during WAIT and during HALT: all outputs 0 immediately; after release, fetch restarts at PC 0 within 2 cycles of FETCH.
